// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: accepts a row-major NxN int8 stream and presents it as a padded 5x5 flat bus.
// Optional feature macro LOADER_IDENTITY_PAD_EN: pads unused diagonal slots with 1 so det(5x5) == det(NxN).
module matrix_stream_loader #(
  parameter int ELEM_W = 8,
  parameter int MAX_N  = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [2:0]                      size,
  input  logic                            in_valid,
  input  logic [ELEM_W-1:0]               in_data,
  output logic                            in_ready,
  output logic [ELEM_W*MAX_N*MAX_N-1:0]   A_flat,
  output logic                            mat_valid,
  input  logic                            mat_ack,
  output logic                            busy,
  output logic                            size_err
);

  localparam int FLAT_W = ELEM_W * MAX_N * MAX_N;
  localparam int IDX_W  = $clog2(FLAT_W);
  localparam logic [2:0] MAX_N3 = 3'(MAX_N);

`ifdef LOADER_IDENTITY_PAD_EN
  localparam bit IDENTITY_PAD = 1'b1;
`else
  localparam bit IDENTITY_PAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [2:0]        r_n;
  logic [2:0]        r_row;
  logic [2:0]        r_col;
  logic [FLAT_W-1:0] r_aFlat;
  logic              r_inReady;
  logic              r_matValid;
  logic              r_busy;
  logic              r_sizeErr;

  logic              w_sizeOk;
  logic              w_startOk;
  logic              w_startBad;
  logic              w_beat;
  logic              w_lastCol;
  logic              w_lastBeat;
  logic [4:0]        w_idx;
  logic [IDX_W-1:0]  w_bitBase;

  // Pad image loaded at start; only diagonal slots beyond the active NxN can be non-zero.
  function automatic logic [FLAT_W-1:0] padPattern(input logic [2:0] n);
    logic [FLAT_W-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (IDENTITY_PAD && (i >= int'(n))) begin
        p[(i * (MAX_N + 1)) * ELEM_W +: ELEM_W] = ELEM_W'(1);
      end
    end
    return p;
  endfunction

  assign w_sizeOk   = (size >= 3'd2) && (size <= MAX_N3);
  assign w_beat     = in_valid && r_inReady;
  assign w_lastCol  = (r_col == (r_n - 3'd1));
  assign w_lastBeat = w_beat && w_lastCol && (r_row == (r_n - 3'd1));
  assign w_idx      = 5'(r_row) * 5'(MAX_N) + 5'(r_col);
  assign w_bitBase  = IDX_W'(w_idx) * IDX_W'(ELEM_W);

  always_comb begin
    w_stateNext = r_state;
    w_startOk   = 1'b0;
    w_startBad  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_sizeOk) begin
            w_startOk   = 1'b1;
            w_stateNext = LOAD;
          end else begin
            w_startBad  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (w_lastBeat) begin
          w_stateNext = FULL;
        end
      end
      FULL: begin
        if (mat_ack) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Status outputs are registered images of the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inReady  <= 1'b0;
      r_matValid <= 1'b0;
      r_busy     <= 1'b0;
      r_sizeErr  <= 1'b0;
    end else begin
      r_inReady  <= (w_stateNext == LOAD);
      r_matValid <= (w_stateNext == FULL);
      r_busy     <= (w_stateNext != IDLE);
      r_sizeErr  <= w_startBad;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_n     <= 3'd0;
      r_row   <= 3'd0;
      r_col   <= 3'd0;
      r_aFlat <= '0;
    end else if (w_startOk) begin
      r_n     <= size;
      r_row   <= 3'd0;
      r_col   <= 3'd0;
      r_aFlat <= padPattern(size);
    end else if (w_beat) begin
      r_aFlat[w_bitBase +: ELEM_W] <= in_data;
      if (w_lastBeat) begin
        r_row <= 3'd0;
        r_col <= 3'd0;
      end else if (w_lastCol) begin
        r_col <= 3'd0;
        r_row <= r_row + 3'd1;
      end else begin
        r_col <= r_col + 3'd1;
      end
    end
  end

  assign in_ready  = r_inReady;
  assign A_flat    = r_aFlat;
  assign mat_valid = r_matValid;
  assign busy      = r_busy;
  assign size_err  = r_sizeErr;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for matrix_stream_loader: randomized loads checked against a 5x5 array model.
// Honours LOADER_IDENTITY_PAD_EN the same way the design does.
module tb_matrix_stream_loader;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   size;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [199:0] A_flat;
  logic         mat_valid;
  logic         mat_ack;
  logic         busy;
  logic         size_err;

  int nVectors     = 0;
  int nMiscompares = 0;

  logic [199:0] expQ[$];
  logic [199:0] lastFlat = '0;
  logic [199:0] heldFlat = '0;
  logic         prevMv   = 1'b0;

`ifdef LOADER_IDENTITY_PAD_EN
  bit identityPad = 1'b1;
`else
  bit identityPad = 1'b0;
`endif

  matrix_stream_loader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .size      (size),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .A_flat    (A_flat),
    .mat_valid (mat_valid),
    .mat_ack   (mat_ack),
    .busy      (busy),
    .size_err  (size_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [199:0] actual, input logic [199:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference: a 5x5 grid of bytes, padded, then filled row-major from the element list.
  function automatic logic [199:0] padOf(input int n);
    logic [199:0] f;
    f = '0;
    for (int i = 0; i < 5; i++)
      if (identityPad && i >= n) f[(i * 5 + i) * 8 +: 8] = 8'd1;
    return f;
  endfunction

  function automatic logic [199:0] modelMatrix(input int n, input logic [7:0] elems[25]);
    logic [7:0]   m[5][5];
    logic [199:0] pad;
    logic [199:0] f;
    pad = padOf(n);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        m[r][c] = pad[(r * 5 + c) * 8 +: 8];
    for (int k = 0; k < n * n; k++)
      m[k / n][k % n] = elems[k];
    f = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        f[(r * 5 + c) * 8 +: 8] = m[r][c];
    return f;
  endfunction

  // Monitor: each rising mat_valid consumes one scoreboard entry; while high the bus must not move.
  always @(negedge clock) begin
    if (mat_valid && !prevMv) begin
      if (expQ.size() == 0) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL unexpected mat_valid: got 1 expected 0");
      end else begin
        checkOutput("matrix", A_flat, expQ.pop_front());
      end
      heldFlat = A_flat;
    end else if (mat_valid) begin
      checkOutput("hold stable", A_flat, heldFlat);
    end
    prevMv = mat_valid;
  end

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " A_flat"}, A_flat, 200'd0);
    checkOutput({tag, " in_ready"}, 200'(in_ready), 200'd0);
    checkOutput({tag, " mat_valid"}, 200'(mat_valid), 200'd0);
    checkOutput({tag, " busy"}, 200'(busy), 200'd0);
    checkOutput({tag, " size_err"}, 200'(size_err), 200'd0);
  endtask

  // Runs one load starting and ending at a negedge; abortBeats>0 resets mid-load instead of finishing.
  task automatic applyStimulus(input int n, input logic [7:0] elems[25], input int stallPct,
                               input int abortBeats, input bit noise, input int holdCycles);
    logic [199:0] exp;
    int idx;
    int cycles;
    int readyCycles;
    bit v;
    exp = modelMatrix(n, elems);
    start    = 1'b1;
    size     = 3'(n);
    in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    in_data  = 8'($urandom);
    @(negedge clock);
    start    = 1'b0;
    in_valid = 1'b0;
    if (noise) size = 3'($urandom);
    checkOutput("in_ready after start", 200'(in_ready), 200'd1);
    checkOutput("busy after start", 200'(busy), 200'd1);
    checkOutput("pad pattern", A_flat, padOf(n));
    if (abortBeats == 0) expQ.push_back(exp);
    idx = 0;
    cycles = 0;
    readyCycles = 0;
    while (idx < n * n && cycles < 1000) begin
      if (abortBeats > 0 && idx == abortBeats) break;
      v = ($urandom_range(0, 99) >= stallPct);
      in_valid = v;
      in_data  = v ? elems[idx] : 8'($urandom);
      if (noise) begin
        start   = ($urandom_range(0, 7) == 0);
        size    = 3'($urandom);
        mat_ack = ($urandom_range(0, 3) == 0);
      end
      if (in_ready) readyCycles++;
      if (v && in_ready) idx++;
      cycles++;
      @(negedge clock);
    end
    in_valid = noise;
    in_data  = 8'($urandom);
    start    = 1'b0;
    mat_ack  = 1'b0;
    if (cycles >= 1000) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL load timeout: got %0d beats expected %0d", idx, n * n);
    end
    if (abortBeats > 0) begin
      reset = 1'b1;
      @(negedge clock);
      reset    = 1'b0;
      in_valid = 1'b0;
      checkIdleZero("after mid-load reset");
      lastFlat = '0;
      return;
    end
    checkOutput("mat_valid latency", 200'(mat_valid), 200'd1);
    checkOutput("in_ready in FULL", 200'(in_ready), 200'd0);
    if (stallPct == 0) checkOutput("ready cycles", 200'(readyCycles), 200'(n * n));
    repeat (holdCycles) begin
      if (noise) begin
        start    = ($urandom_range(0, 3) == 0);
        size     = 3'($urandom_range(2, 5));
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      @(negedge clock);
    end
    checkOutput("mat_valid before ack", 200'(mat_valid), 200'd1);
    start    = 1'b0;
    in_valid = 1'b0;
    mat_ack  = 1'b1;
    @(negedge clock);
    mat_ack = 1'b0;
    checkOutput("mat_valid after ack", 200'(mat_valid), 200'd0);
    checkOutput("busy after ack", 200'(busy), 200'd0);
    checkOutput("A_flat kept in IDLE", A_flat, exp);
    lastFlat = exp;
  endtask

  task automatic applyBadSize(input logic [2:0] s);
    start = 1'b1;
    size  = s;
    @(negedge clock);
    start = 1'b0;
    checkOutput("size_err pulse", 200'(size_err), 200'd1);
    checkOutput("busy on bad size", 200'(busy), 200'd0);
    checkOutput("A_flat on bad size", A_flat, lastFlat);
    @(negedge clock);
    checkOutput("size_err one cycle", 200'(size_err), 200'd0);
    checkOutput("busy after bad size", 200'(busy), 200'd0);
  endtask

  initial begin
    logic [7:0] e[25];
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    size     = 3'd0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    mat_ack  = 1'b0;
    repeat (2) @(negedge clock);
    checkIdleZero("reset");
    reset = 1'b0;
    @(negedge clock);

    for (int k = 0; k < 25; k++) e[k] = 8'($urandom);
    applyStimulus(5, e, 0, 7, 1'b0, 0);

    for (int k = 0; k < 25; k++) e[k] = 8'(k + 1);
    applyStimulus(5, e, 0, 0, 1'b0, 2);

    for (int k = 0; k < 25; k++) e[k] = 8'd0;
    e[0] = 8'd2;
    e[4] = 8'd3;
    e[8] = 8'd4;
    applyStimulus(3, e, 0, 0, 1'b0, 1);

    for (int k = 0; k < 25; k++) e[k] = 8'($urandom);
    applyStimulus(2, e, 50, 0, 1'b0, 10);

    applyBadSize(3'd1);
    applyBadSize(3'd6);
    applyBadSize(3'd0);
    applyBadSize(3'd7);

    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(2, 5);
      for (int k = 0; k < 25; k++) e[k] = 8'($urandom);
      applyStimulus(n, e, 30, 0, 1'b1, $urandom_range(0, 6));
    end

    applyBadSize(3'd1);
    repeat (2) @(negedge clock);
    checkOutput("scoreboard drained", 200'(expQ.size()), 200'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
